// File: rtl/error_calc_multi.sv
// rtl/error_calc_multi.sv - multi-channel servo error stage: e = ref - yk and de = e(k) - e(k-1)
// Channels are processed serially, one per clock, from values captured when the run starts.
module error_calc_multi #(
   parameter int ANCHO     = 19,
   parameter int N_CANALES = 2,
   parameter int DEADBAND  = 0
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_Ready,
   input  logic                         i_clr_hist,
   input  logic [N_CANALES*ANCHO-1:0]   i_ref,
   input  logic [N_CANALES*ANCHO-1:0]   i_yk,
   output logic [N_CANALES*ANCHO-1:0]   o_Error,
   output logic [N_CANALES*ANCHO-1:0]   o_dError,
   output logic [N_CANALES-1:0]         o_sat,
   output logic                         o_busy,
   output logic                         o_ListoERROR
);

   localparam int                IDX_W = (N_CANALES > 1) ? $clog2(N_CANALES) : 1;
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_CANALES - 1);
   localparam logic [ANCHO-1:0]  MAX_A = {1'b0, {(ANCHO-1){1'b1}}};
   localparam logic [ANCHO-1:0]  MIN_A = {1'b1, {(ANCHO-1){1'b0}}};
   localparam logic [ANCHO:0]    DB    = (ANCHO+1)'(DEADBAND);

   typedef enum logic {S_IDLE, S_CALC} state_t;

   state_t                        r_state, w_next;
   logic [IDX_W-1:0]              r_idx;
   logic [N_CANALES*ANCHO-1:0]    r_ref_cap, r_yk_cap;
   logic [N_CANALES*ANCHO-1:0]    r_error, r_derror;
   logic [N_CANALES-1:0]          r_sat;
   logic                          r_listo;
   logic [ANCHO-1:0]              r_eprev [N_CANALES];

   logic [ANCHO-1:0]              w_ref, w_yk, w_eprev, w_esat, w_e, w_de;
   logic [ANCHO:0]                w_d, w_dd, w_abs;
   logic                          w_clip_e, w_clip_de;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_Ready) w_next = S_CALC;
         S_CALC:  if (r_idx == LAST) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Overflow of the ANCHO+1 bit difference shows as disagreement of its top two bits.
   always_comb begin
      w_ref     = r_ref_cap[r_idx*ANCHO +: ANCHO];
      w_yk      = r_yk_cap[r_idx*ANCHO +: ANCHO];
      w_eprev   = r_eprev[r_idx];
      w_d       = {w_ref[ANCHO-1], w_ref} - {w_yk[ANCHO-1], w_yk};
      w_clip_e  = w_d[ANCHO] ^ w_d[ANCHO-1];
      w_esat    = w_clip_e ? (w_d[ANCHO] ? MIN_A : MAX_A) : w_d[ANCHO-1:0];
      w_abs     = w_esat[ANCHO-1] ? (~{1'b1, w_esat} + 1'b1) : {1'b0, w_esat};
      w_e       = (w_abs <= DB) ? '0 : w_esat;
      w_dd      = {w_e[ANCHO-1], w_e} - {w_eprev[ANCHO-1], w_eprev};
      w_clip_de = w_dd[ANCHO] ^ w_dd[ANCHO-1];
      w_de      = w_clip_de ? (w_dd[ANCHO] ? MIN_A : MAX_A) : w_dd[ANCHO-1:0];
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_idx     <= '0;
         r_ref_cap <= '0;
         r_yk_cap  <= '0;
         r_error   <= '0;
         r_derror  <= '0;
         r_sat     <= '0;
         r_listo   <= 1'b0;
         for (int j = 0; j < N_CANALES; j++) r_eprev[j] <= '0;
      end else begin
         r_listo <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_clr_hist)
                  for (int j = 0; j < N_CANALES; j++) r_eprev[j] <= '0;
               if (i_Ready) begin
                  r_ref_cap <= i_ref;
                  r_yk_cap  <= i_yk;
                  r_idx     <= '0;
               end
            end
            S_CALC: begin
               // Only channels still ahead of the cursor lose their history.
               if (i_clr_hist)
                  for (int j = 0; j < N_CANALES; j++)
                     if (j > int'(r_idx)) r_eprev[j] <= '0;
               r_eprev[r_idx]                  <= w_e;
               r_error[r_idx*ANCHO +: ANCHO]   <= w_e;
               r_derror[r_idx*ANCHO +: ANCHO]  <= w_de;
               r_sat[r_idx]                    <= w_clip_e | w_clip_de;
               if (r_idx == LAST) begin
                  r_idx   <= '0;
                  r_listo <= 1'b1;
               end else begin
                  r_idx   <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_Error      = r_error;
   assign o_dError     = r_derror;
   assign o_sat        = r_sat;
   assign o_busy       = (r_state == S_CALC);
   assign o_ListoERROR = r_listo;

endmodule

// File: tb/tb_error_calc_multi.sv
// tb/tb_error_calc_multi.sv - randomized self-checking bench for error_calc_multi (deadband 0 and 5)
module tb_error_calc_multi;

   localparam int     W    = 19;
   localparam int     N    = 2;
   localparam longint MAXV = 262143;
   localparam longint MINV = -262144;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            ready = 1'b0;
   logic            clr = 1'b0;
   logic [N*W-1:0]  ref_bus = '0;
   logic [N*W-1:0]  yk_bus = '0;
   logic [N*W-1:0]  err [2];
   logic [N*W-1:0]  derr [2];
   logic [N-1:0]    sat [2];
   logic            busy [2];
   logic            listo [2];

   int     n_vec = 0;
   int     n_bad = 0;
   int     ref_v [N];
   int     yk_v [N];
   longint dbv [2] = '{0, 5};
   longint exp_e [2][N];
   longint exp_de [2][N];
   bit     exp_s [2][N];
   longint eprev [2][N];

   always #5 clk = ~clk;

   error_calc_multi #(.ANCHO(W), .N_CANALES(N), .DEADBAND(0)) dut0 (
      .i_clk(clk), .i_reset(rst), .i_Ready(ready), .i_clr_hist(clr),
      .i_ref(ref_bus), .i_yk(yk_bus), .o_Error(err[0]), .o_dError(derr[0]),
      .o_sat(sat[0]), .o_busy(busy[0]), .o_ListoERROR(listo[0]));

   error_calc_multi #(.ANCHO(W), .N_CANALES(N), .DEADBAND(5)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_Ready(ready), .i_clr_hist(clr),
      .i_ref(ref_bus), .i_yk(yk_bus), .o_Error(err[1]), .o_dError(derr[1]),
      .o_sat(sat[1]), .o_busy(busy[1]), .o_ListoERROR(listo[1]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < N; c++) begin
            exp_e[d][c] = 0; exp_de[d][c] = 0; exp_s[d][c] = 0; eprev[d][c] = 0;
         end
   endtask

   task automatic model_ch(input int c);
      longint diff, e, de;
      bit     c1, c2;
      for (int d = 0; d < 2; d++) begin
         diff = longint'(ref_v[c]) - longint'(yk_v[c]);
         c1 = 0; c2 = 0;
         if (diff > MAXV) begin diff = MAXV; c1 = 1; end
         else if (diff < MINV) begin diff = MINV; c1 = 1; end
         e = (((diff < 0) ? -diff : diff) <= dbv[d]) ? 0 : diff;
         de = e - eprev[d][c];
         if (de > MAXV) begin de = MAXV; c2 = 1; end
         else if (de < MINV) begin de = MINV; c2 = 1; end
         exp_e[d][c] = e; exp_de[d][c] = de; exp_s[d][c] = c1 | c2; eprev[d][c] = e;
      end
   endtask

   task automatic drive_buses();
      for (int c = 0; c < N; c++) begin
         ref_bus[c*W +: W] = ref_v[c][W-1:0];
         yk_bus[c*W +: W]  = yk_v[c][W-1:0];
      end
   endtask

   // One complete run: Ready at edge 0, channels at edges 1..N, pulse checked at edge N and N+1.
   task automatic do_run(input string name, input bit clr0, input bit clr1, input bit noisy);
      longint act_e, act_de;
      drive_buses();
      ready = 1'b1; clr = clr0;
      if (clr0) for (int d = 0; d < 2; d++) for (int c = 0; c < N; c++) eprev[d][c] = 0;
      tick();
      n_vec++;
      if (busy[0] !== 1'b1 || listo[0] !== 1'b0) begin
         n_bad++; $display("FAIL %s edge0 busy/listo got %b/%b want 1/0", name, busy[0], listo[0]);
      end
      ready = noisy; clr = clr1;
      if (noisy) begin ref_bus = {$urandom, $urandom}; yk_bus = {$urandom, $urandom}; end
      tick();
      model_ch(0);
      if (clr1) for (int d = 0; d < 2; d++) eprev[d][1] = 0;
      n_vec++;
      if (busy[0] !== 1'b1 || listo[0] !== 1'b0) begin
         n_bad++; $display("FAIL %s edge1 busy/listo got %b/%b want 1/0", name, busy[0], listo[0]);
      end
      clr = noisy;
      tick();
      model_ch(1);
      n_vec++;
      if (busy[0] !== 1'b0 || listo[0] !== 1'b1 || listo[1] !== 1'b1) begin
         n_bad++; $display("FAIL %s edge2 busy/listo0/listo1 got %b/%b/%b want 0/1/1",
                           name, busy[0], listo[0], listo[1]);
      end
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < N; c++) begin
            act_e  = longint'($signed(err[d][c*W +: W]));
            act_de = longint'($signed(derr[d][c*W +: W]));
            n_vec++;
            if (act_e !== exp_e[d][c] || act_de !== exp_de[d][c] || sat[d][c] !== exp_s[d][c]) begin
               n_bad++;
               $display("FAIL %s dut%0d ch%0d e/de/sat got %0d/%0d/%b want %0d/%0d/%b",
                        name, d, c, act_e, act_de, sat[d][c], exp_e[d][c], exp_de[d][c], exp_s[d][c]);
            end
         end
      ready = 1'b0; clr = 1'b0;
      tick();
      n_vec++;
      if (busy[0] !== 1'b0 || listo[0] !== 1'b0) begin
         n_bad++; $display("FAIL %s edge3 busy/listo got %b/%b want 0/0", name, busy[0], listo[0]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      model_reset();
      n_vec++;
      if (err[0] !== '0 || derr[0] !== '0 || sat[0] !== '0 || busy[0] !== 1'b0 || listo[0] !== 1'b0) begin
         n_bad++; $display("FAIL reset outputs got err=%h derr=%h sat=%b busy=%b listo=%b want all 0",
                           err[0], derr[0], sat[0], busy[0], listo[0]);
      end
      rst = 1'b0;
      tick();
      n_vec++;
      if (busy[0] !== 1'b0 || listo[0] !== 1'b0) begin
         n_bad++; $display("FAIL reset_idle busy/listo got %b/%b want 0/0", busy[0], listo[0]);
      end
   endtask

   task automatic test_basic();
      ref_v = '{1000, 500}; yk_v = '{400, 600};
      do_run("basic", 0, 0, 0);
      do_run("basic_repeat", 0, 0, 0);
      do_run("basic_clr", 1, 0, 0);
   endtask

   task automatic test_saturation();
      ref_v = '{262143, -262144}; yk_v = '{-262144, 1};
      do_run("sat_e", 0, 0, 0);
      ref_v = '{-262144, 262143}; yk_v = '{0, 0};
      do_run("sat_de", 0, 0, 0);
   endtask

   task automatic test_deadband();
      ref_v = '{10, 10}; yk_v = '{5, 4};
      do_run("deadband", 1, 0, 0);
      ref_v = '{-10, 0}; yk_v = '{-5, 6};
      do_run("deadband_neg", 0, 0, 0);
   endtask

   task automatic test_clr_midcalc();
      ref_v = '{300, -700}; yk_v = '{0, 0};
      do_run("clr_mid_prime", 0, 0, 0);
      do_run("clr_mid", 0, 1, 0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 25; r++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 2) == 0) begin
               ref_v[c] = int'($urandom_range(0, 20)) - 10;
               yk_v[c]  = int'($urandom_range(0, 20)) - 10;
            end else begin
               ref_v[c] = int'($urandom_range(0, 524287)) - 262144;
               yk_v[c]  = int'($urandom_range(0, 524287)) - 262144;
            end
         end
         do_run("random", bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0),
                bit'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_back_to_back();
      longint act_e, act_de;
      ref_v = '{12345, -2000}; yk_v = '{-100, 3000};
      drive_buses();
      ready = 1'b1; clr = 1'b0;
      for (int e = 0; e < 9; e++) begin
         tick();
         if (e == 3) for (int d = 0; d < 2; d++) for (int c = 0; c < N; c++) eprev[d][c] = 0;
         clr = (e == 2);
         if (e % 3 == 1) model_ch(0);
         if (e % 3 == 2) model_ch(1);
         n_vec++;
         if (listo[0] !== bit'(e % 3 == 2) || busy[0] !== bit'(e % 3 != 2)) begin
            n_bad++; $display("FAIL b2b edge%0d listo/busy got %b/%b want %b/%b",
                              e, listo[0], busy[0], e % 3 == 2, e % 3 != 2);
         end
         if (e % 3 == 2)
            for (int c = 0; c < N; c++) begin
               act_e  = longint'($signed(err[0][c*W +: W]));
               act_de = longint'($signed(derr[0][c*W +: W]));
               n_vec++;
               if (act_e !== exp_e[0][c] || act_de !== exp_de[0][c]) begin
                  n_bad++; $display("FAIL b2b edge%0d ch%0d e/de got %0d/%0d want %0d/%0d",
                                    e, c, act_e, act_de, exp_e[0][c], exp_de[0][c]);
               end
            end
      end
      ready = 1'b0; clr = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      ref_v = '{777, 888}; yk_v = '{1, 2};
      drive_buses();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      @(posedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      n_vec++;
      if (err[0] !== '0 || derr[0] !== '0 || sat[0] !== '0 || busy[0] !== 1'b0 || listo[0] !== 1'b0
          || err[1] !== '0) begin
         n_bad++; $display("FAIL abort outputs got err=%h derr=%h sat=%b busy=%b listo=%b want all 0",
                           err[0], derr[0], sat[0], busy[0], listo[0]);
      end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_vec++;
         if (listo[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_bad++; $display("FAIL abort_quiet cycle%0d listo/busy got %b/%b want 0/0", k, listo[0], busy[0]);
         end
      end
      do_run("after_abort", 0, 0, 0);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_saturation();
      test_deadband();
      test_clr_midcalc();
      test_back_to_back();
      test_random();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
